final_subtractor_pipe: RTL and testbench

- Pipelined unsigned subtractor for the fp32 5-to-1 add tree. It is the effective-subtraction counterpart of the tree's final carry-propagate adder.
- Takes two aligned WIDTH-bit magnitudes and returns |a-b| with a sign flag and a zero flag.
- Three register stages: low-half borrow chain, high-half borrow chain, conditional two's-complement negate.
- Valid/ready handshake on both sides; full-throughput with backpressure.

---
 rtl/final_subtractor_pipe.sv | 187 ++++++++++++++++++
 tb/tb_final_subtractor_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/final_subtractor_pipe.sv
// ---------------------------------------------------------------------------
// final_subtractor_pipe
//
// Pipelined unsigned subtractor for the fp32 5-to-1 add tree. This is the
// effective-subtraction partner of the tree's final carry-propagate adder:
// it takes two aligned WIDTH-bit magnitudes and returns |a-b| together with
// a sign flag (a<b) and a zero flag (a==b).
//
// Pipeline (three register stages, full throughput, backpressure-aware):
//   S1  low-half borrow ripple (HALF bits); high halves carried forward
//   S2  high-half borrow ripple using the registered low borrow
//   S3  conditional two's-complement negate, sign/zero flags
//
// Parameters:
//   WIDTH  operand width, must be even and >= 4 (default 32)
//   HALF   WIDTH/2, split point of the borrow chain (derived)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  pair accepted this cycle (combinational from out_ready
//                   and the stage valid bits only)
//   a, b       in   WIDTH-bit unsigned minuend / subtrahend
//   out_valid  out  result valid (registered)
//   out_ready  in   downstream accepts the result
//   diff_mag   out  |a-b| (registered)
//   sign       out  1 when a<b (registered)
//   zero       out  1 when a==b (registered)
//   diff_raw   out  {borrow_out, diff}, WIDTH+1 bits, only when the macro
//                   FINAL_SUB_RAW_OUT_EN is defined
//
// Optional feature macro: FINAL_SUB_RAW_OUT_EN
// ---------------------------------------------------------------------------
module final_subtractor_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff_mag,
    output logic             sign,
    output logic             zero
`ifdef FINAL_SUB_RAW_OUT_EN
    ,
    output logic [WIDTH:0]   diff_raw
`endif
);

    localparam int HALF = WIDTH / 2;

    // Bit-level propagate/generate borrow ripple. Returns {borrow_out, diff}.
    // g: this bit borrows on its own (x=0, y=1)
    // p: this bit passes an incoming borrow through (x==y)
    function automatic logic [HALF:0] sub_ripple(
        input logic [HALF-1:0] x,
        input logic [HALF-1:0] y,
        input logic            bin
    );
        logic            br;
        logic            p;
        logic            g;
        logic [HALF-1:0] d;
        br = bin;
        d  = '0;
        for (int i = 0; i < HALF; i++) begin
            p    = ~(x[i] ^ y[i]);
            g    = ~x[i] & y[i];
            d[i] = x[i] ^ y[i] ^ br;
            br   = g | (p & br);
        end
        return {br, d};
    endfunction

    // ---------------- stage registers ----------------
    logic             r_v1, r_v2, r_v3;
    logic [HALF-1:0]  r_dlo1, r_ahi1, r_bhi1;
    logic             r_blo1;
    logic [WIDTH-1:0] r_diff2;
    logic             r_bout2;
    logic [WIDTH-1:0] r_mag3;
    logic             r_sign3, r_zero3;
`ifdef FINAL_SUB_RAW_OUT_EN
    logic [WIDTH:0]   r_raw3;
`endif

    // ---------------- handshake / stall chain ----------------
    // A stage may load when it is empty or its contents move on this cycle,
    // so bubbles collapse even while the output is stalled.
    logic w_adv1, w_adv2, w_adv3;

    always_comb begin
        w_adv3 = ~r_v3 | out_ready;
        w_adv2 = ~r_v2 | w_adv3;
        w_adv1 = ~r_v1 | w_adv2;
    end

    assign in_ready = w_adv1;

    // ---------------- datapath combinational ----------------
    logic [HALF:0]    w_lo;
    logic [HALF:0]    w_hi;
    logic [WIDTH-1:0] w_neg;

    always_comb begin
        w_lo  = sub_ripple(a[HALF-1:0], b[HALF-1:0], 1'b0);
        w_hi  = sub_ripple(r_ahi1, r_bhi1, r_blo1);
        w_neg = ~r_diff2 + {{(WIDTH-1){1'b0}}, 1'b1};
    end

    // ---------------- stage 1 ----------------
    // Data registers only capture real beats; the valid bit carries bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_dlo1 <= '0;
            r_blo1 <= 1'b0;
            r_ahi1 <= '0;
            r_bhi1 <= '0;
        end else if (w_adv1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_dlo1 <= w_lo[HALF-1:0];
                r_blo1 <= w_lo[HALF];
                r_ahi1 <= a[WIDTH-1:HALF];
                r_bhi1 <= b[WIDTH-1:HALF];
            end
        end
    end

    // ---------------- stage 2 ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_diff2 <= '0;
            r_bout2 <= 1'b0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_diff2 <= {w_hi[HALF-1:0], r_dlo1};
                r_bout2 <= w_hi[HALF];
            end
        end
    end

    // ---------------- stage 3 ----------------
    // A zero difference can only come from a==b, which never borrows, so
    // sign and zero are mutually exclusive by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3    <= 1'b0;
            r_mag3  <= '0;
            r_sign3 <= 1'b0;
            r_zero3 <= 1'b0;
        end else if (w_adv3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_mag3  <= r_bout2 ? w_neg : r_diff2;
                r_sign3 <= r_bout2;
                r_zero3 <= (r_diff2 == '0);
            end
        end
    end

`ifdef FINAL_SUB_RAW_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw3 <= '0;
        end else if (w_adv3 && r_v2) begin
            r_raw3 <= {r_bout2, r_diff2};
        end
    end

    assign diff_raw = r_raw3;
`endif

    assign out_valid = r_v3;
    assign diff_mag  = r_mag3;
    assign sign      = r_sign3;
    assign zero      = r_zero3;

endmodule

// File: tb/tb_final_subtractor_pipe.sv
// ---------------------------------------------------------------------------
// tb_final_subtractor_pipe
//
// Directed self-checking bench for final_subtractor_pipe (WIDTH=32).
// Covers reset state, single-beat latency and arithmetic corners, a
// six-beat stream with an output stall, and reset with beats in flight.
// ---------------------------------------------------------------------------
module tb_final_subtractor_pipe;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff_mag;
    logic         sign;
    logic         zero;
`ifdef FINAL_SUB_RAW_OUT_EN
    logic [W:0]   diff_raw;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    final_subtractor_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff_mag  (diff_mag),
        .sign      (sign),
        .zero      (zero)
`ifdef FINAL_SUB_RAW_OUT_EN
        ,
        .diff_raw  (diff_raw)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated beat: accept, confirm no early output, then check the
    // result exactly three cycles after the accepting cycle.
    task automatic one_beat(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic [W-1:0] emag, input logic esign, input logic ezero,
                            input logic [W:0] eraw);
        @(negedge clk);
        in_valid = 1'b1; a = va; b = vb; out_ready = 1'b1;
        #1 chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".early_c1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, ".early_c2"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".diff_mag"}, 64'(diff_mag), 64'(emag));
        chk({tag, ".sign"}, 64'(sign), 64'(esign));
        chk({tag, ".zero"}, 64'(zero), 64'(ezero));
`ifdef FINAL_SUB_RAW_OUT_EN
        chk({tag, ".diff_raw"}, 64'(diff_raw), 64'(eraw));
`else
        if (eraw != eraw) n_fail++;  // raw port absent in this build
`endif
        @(negedge clk);
        chk({tag, ".drained"}, 64'(out_valid), 64'd0);
    endtask

    // Stream stimulus
    logic [W-1:0] sa [6] = '{32'd10, 32'd1, 32'hFFFF_FFFF, 32'd100, 32'h1234_5678, 32'd0};
    logic [W-1:0] sb [6] = '{32'd3,  32'd2, 32'd1,         32'd100, 32'h8765_4321, 32'd0};
    logic [W+1:0] exp_q[$];   // {zero, sign, mag}

    initial begin
        int         sent;
        int         rcvd;
        int         nready0;
        logic       held;
        logic [W-1:0] held_mag;
        logic [W+1:0] e;
        logic [W-1:0] ea;
        logic [W-1:0] eb;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.diff_mag", 64'(diff_mag), 64'd0);
        chk("rst.sign", 64'(sign), 64'd0);
        chk("rst.zero", 64'(zero), 64'd0);
`ifdef FINAL_SUB_RAW_OUT_EN
        chk("rst.diff_raw", 64'(diff_raw), 64'd0);
`endif
        rst_n = 1'b1;
        #1 chk("rst.in_ready_after", 64'(in_ready), 64'd1);

        one_beat("v5m3",     32'd5,          32'd3,          32'd2,          1'b0, 1'b0, 33'h0_0000_0002);
        one_beat("v3m5",     32'd3,          32'd5,          32'd2,          1'b1, 1'b0, 33'h1_FFFF_FFFE);
        one_beat("eq",       32'h7F80_0000,  32'h7F80_0000,  32'd0,          1'b0, 1'b1, 33'h0_0000_0000);
        one_beat("halfbrw",  32'h0001_0000,  32'd1,          32'h0000_FFFF,  1'b0, 1'b0, 33'h0_0000_FFFF);
        one_beat("zminmax",  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b0, 33'h1_0000_0001);
        one_beat("maxmz",    32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0, 33'h0_FFFF_FFFF);
        one_beat("msbsplit", 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0, 33'h0_0000_0001);

        // Six back-to-back pairs, out_ready low during cycles 4..8.
        sent = 0; rcvd = 0; nready0 = 0; held = 1'b0; held_mag = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (sent < 6) begin
                in_valid = 1'b1; a = sa[sent]; b = sb[sent];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(c >= 4 && c <= 8);
            #1;
            if (held) begin
                chk("stall.hold_valid", 64'(out_valid), 64'd1);
                chk("stall.hold_mag", 64'(diff_mag), 64'(held_mag));
            end
            held     = out_valid && !out_ready;
            held_mag = diff_mag;
            if (c == 4) chk("stream.full_in_ready", 64'(in_ready), 64'd0);
            if (!in_ready) nready0++;
            if (in_valid && in_ready) begin
                ea = sa[sent]; eb = sb[sent];
                e[W-1:0] = (ea >= eb) ? ea - eb : eb - ea;
                e[W]     = (ea < eb);
                e[W+1]   = (ea == eb);
                exp_q.push_back(e);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream.extra_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("stream.mag%0d", rcvd), 64'(diff_mag), 64'(e[W-1:0]));
                    chk($sformatf("stream.sign%0d", rcvd), 64'(sign), 64'(e[W]));
                    chk($sformatf("stream.zero%0d", rcvd), 64'(zero), 64'(e[W+1]));
                end
                rcvd++;
            end
        end
        chk("stream.sent", 64'(sent), 64'd6);
        chk("stream.rcvd", 64'(rcvd), 64'd6);
        chk("stream.not_ready_cycles", 64'(nready0), 64'd5);

        // Reset with beats in flight while the output is stalled.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 32'd50; b = 32'd8;
        @(negedge clk);
        a = 32'd9; b = 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("inflight.out_valid", 64'(out_valid), 64'd1);
        chk("inflight.diff_mag", 64'(diff_mag), 64'd42);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.diff_mag", 64'(diff_mag), 64'd0);
        chk("midrst.sign", 64'(sign), 64'd0);
        chk("midrst.zero", 64'(zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1 chk("postrst.in_ready", 64'(in_ready), 64'd1);
        repeat (3) begin
            @(negedge clk);
            chk("postrst.no_stale", 64'(out_valid), 64'd0);
        end
        one_beat("postrst", 32'd1000, 32'd1234, 32'd234, 1'b1, 1'b0, 33'h1_FFFF_FF16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
